// File: rtl/sprite_blitter_if.sv
// ROM read port and LT24 pixel-write port of the sprite blitter.
// The master side is the blitter; the slave side is the ROM plus LCD driver.
interface sprite_blitter_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] romAddr;
   logic [15:0]       romData;
   logic [7:0]        xAddr;
   logic [8:0]        yAddr;
   logic [15:0]       pixelData;
   logic              pixelWrite;
   logic              pixelReady;

   modport master (
      output romAddr, xAddr, yAddr, pixelData, pixelWrite,
      input  romData, pixelReady
   );

   modport slave (
      input  romAddr, xAddr, yAddr, pixelData, pixelWrite,
      output romData, pixelReady
   );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: reads a W x H sprite from ROM and writes it to the LT24 pixel port
// with optional flips, 2x scaling, screen clipping, transparency and abort.
module sprite_blitter #(
   parameter int unsigned SCREEN_W    = 240,
   parameter int unsigned SCREEN_H    = 320,
   parameter int unsigned ROM_LATENCY = 2,
   parameter int unsigned ADDR_W      = 16,
   parameter logic [15:0] TRANSPARENT = 16'h0001
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              draw,
   input  logic              abort,
   input  logic [ADDR_W-1:0] romBase,
   input  logic [9:0]        xOrigin,
   input  logic [9:0]        yOrigin,
   input  logic              flipH,
   input  logic              flipV,
   input  logic              scale2,
   sprite_blitter_if.master  bus,
   output logic              ready,
   output logic              done,
   output logic              aborted,
   output logic [8:0]        imgWidth,
   output logic [8:0]        imgHeight,
   output logic [17:0]       writeCount
);

   typedef enum logic [2:0] {
      StIdle, StHdrW, StHdrH, StFetch, StEmit, StWrite, StAdvance, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] base_q, base_d, rom_addr_q, rom_addr_d;
   logic [9:0]        xo_q, xo_d, yo_q, yo_d;
   logic              fh_q, fh_d, fv_q, fv_d, s2_q, s2_d;
   logic [8:0]        c_q, c_d, r_q, r_d, w_q, w_d, h_q, h_d;
   logic              i_q, i_d, j_q, j_d;
   logic [15:0]       colour_q, colour_d, pix_q, pix_d;
   logic [7:0]        x_q, x_d;
   logic [8:0]        y_q, y_d;
   logic              wr_q, wr_d, ready_q, ready_d, done_q, done_d, aborted_q, aborted_d;
   logic              draw_prev_q, draw_prev_d;
   logic [17:0]       count_q, count_d;

   logic [10:0] dst_x, dst_y;
   logic        writable, lat_hit;

   // Signed 11-bit destination of the current sub-pixel.
   assign dst_x = {xo_q[9], xo_q} + (s2_q ? {1'b0, c_q, 1'b0} : {2'b00, c_q}) + {10'd0, i_q};
   assign dst_y = {yo_q[9], yo_q} + (s2_q ? {1'b0, r_q, 1'b0} : {2'b00, r_q}) + {10'd0, j_q};
   assign writable = !dst_x[10] && (dst_x < 11'(SCREEN_W)) && !dst_y[10] &&
                     (dst_y < 11'(SCREEN_H)) && (colour_q != TRANSPARENT);
   assign lat_hit = (wait_q == 3'(ROM_LATENCY));

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] c, input logic [8:0] r,
                                                  input logic [8:0] w, input logic [8:0] h);
      logic [8:0]  sc, sr;
      logic [17:0] prod;
      sc   = fh_q ? w - 9'd1 - c : c;
      sr   = fv_q ? h - 9'd1 - r : r;
      prod = sr * w;
      return base_q + ADDR_W'(2) + ADDR_W'(prod) + ADDR_W'(sc);
   endfunction

   always_comb begin
      state_d = state_q;  wait_d = wait_q;  base_d = base_q;  rom_addr_d = rom_addr_q;
      xo_d = xo_q;  yo_d = yo_q;  fh_d = fh_q;  fv_d = fv_q;  s2_d = s2_q;
      c_d = c_q;  r_d = r_q;  w_d = w_q;  h_d = h_q;  i_d = i_q;  j_d = j_q;
      colour_d = colour_q;  pix_d = pix_q;  x_d = x_q;  y_d = y_q;  wr_d = wr_q;
      aborted_d = aborted_q;  count_d = count_q;  draw_prev_d = draw;
      unique case (state_q)
         StIdle: if (draw && !draw_prev_q) begin
            base_d = romBase;  xo_d = xOrigin;  yo_d = yOrigin;
            fh_d = flipH;  fv_d = flipV;  s2_d = scale2;
            count_d = '0;  aborted_d = 1'b0;  rom_addr_d = romBase;  wait_d = '0;
            state_d = StHdrW;
         end
         StHdrW: if (lat_hit) begin
            w_d = bus.romData[8:0];  rom_addr_d = base_q + ADDR_W'(1);  wait_d = '0;
            state_d = StHdrH;
         end else wait_d = wait_q + 3'd1;
         StHdrH: if (lat_hit) begin
            h_d = bus.romData[8:0];  wait_d = '0;
            c_d = '0;  r_d = '0;  i_d = 1'b0;  j_d = 1'b0;
            rom_addr_d = pix_addr(9'd0, 9'd0, w_q, bus.romData[8:0]);
            state_d = (w_q == '0 || bus.romData[8:0] == '0) ? StDone : StFetch;
         end else wait_d = wait_q + 3'd1;
         StFetch: if (lat_hit) begin
            colour_d = bus.romData;  wait_d = '0;  state_d = StEmit;
         end else wait_d = wait_q + 3'd1;
         StEmit: if (writable) begin
            x_d = dst_x[7:0];  y_d = dst_y[8:0];  pix_d = colour_q;  wr_d = 1'b1;
            state_d = StWrite;
         end else state_d = StAdvance;
         StWrite: begin
            // An abort seen mid-write is remembered so the write can finish first.
            if (abort) aborted_d = 1'b1;
            if (bus.pixelReady) begin
               wr_d = 1'b0;
               if (count_q != '1) count_d = count_q + 18'd1;
               state_d = (aborted_q || abort) ? StDone : StAdvance;
            end
         end
         StAdvance: if (s2_q && !i_q) begin
            i_d = 1'b1;  state_d = StEmit;
         end else if (s2_q && !j_q) begin
            i_d = 1'b0;  j_d = 1'b1;  state_d = StEmit;
         end else begin
            i_d = 1'b0;  j_d = 1'b0;
            if (c_q != w_q - 9'd1) begin
               c_d = c_q + 9'd1;  rom_addr_d = pix_addr(c_q + 9'd1, r_q, w_q, h_q);
               state_d = StFetch;
            end else if (r_q != h_q - 9'd1) begin
               c_d = '0;  r_d = r_q + 9'd1;  rom_addr_d = pix_addr(9'd0, r_q + 9'd1, w_q, h_q);
               state_d = StFetch;
            end else state_d = StDone;
         end
         StDone: state_d = StIdle;
      endcase
      if (abort && (state_q inside {StHdrW, StHdrH, StFetch, StEmit, StAdvance})) begin
         state_d = StDone;  aborted_d = 1'b1;  wr_d = 1'b0;
      end
      ready_d = (state_d == StIdle);
      done_d  = (state_d == StDone);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;  wait_q <= '0;  base_q <= '0;  rom_addr_q <= '0;
         xo_q <= '0;  yo_q <= '0;  fh_q <= 1'b0;  fv_q <= 1'b0;  s2_q <= 1'b0;
         c_q <= '0;  r_q <= '0;  w_q <= '0;  h_q <= '0;  i_q <= 1'b0;  j_q <= 1'b0;
         colour_q <= '0;  pix_q <= '0;  x_q <= '0;  y_q <= '0;  wr_q <= 1'b0;
         ready_q <= 1'b0;  done_q <= 1'b0;  aborted_q <= 1'b0;  count_q <= '0;
         // Treat draw as already high so a level held through reset cannot start a draw.
         draw_prev_q <= 1'b1;
      end else begin
         state_q <= state_d;  wait_q <= wait_d;  base_q <= base_d;  rom_addr_q <= rom_addr_d;
         xo_q <= xo_d;  yo_q <= yo_d;  fh_q <= fh_d;  fv_q <= fv_d;  s2_q <= s2_d;
         c_q <= c_d;  r_q <= r_d;  w_q <= w_d;  h_q <= h_d;  i_q <= i_d;  j_q <= j_d;
         colour_q <= colour_d;  pix_q <= pix_d;  x_q <= x_d;  y_q <= y_d;  wr_q <= wr_d;
         ready_q <= ready_d;  done_q <= done_d;  aborted_q <= aborted_d;  count_q <= count_d;
         draw_prev_q <= draw_prev_d;
      end
   end

   assign bus.romAddr    = rom_addr_q;
   assign bus.xAddr      = x_q;
   assign bus.yAddr      = y_q;
   assign bus.pixelData  = pix_q;
   assign bus.pixelWrite = wr_q;
   assign ready          = ready_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign imgWidth       = w_q;
   assign imgHeight      = h_q;
   assign writeCount     = count_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a high-level reference model queues expected pixel
// writes per draw; a monitor pops and compares each write the LCD side accepts.
module tb_sprite_blitter;
   localparam int          L = 2;
   localparam logic [15:0] T = 16'h0001;

   logic        clock = 1'b0, reset = 1'b1, draw = 1'b0, abort = 1'b0;
   logic [15:0] romBase = '0;
   logic [9:0]  xOrigin = '0, yOrigin = '0;
   logic        flipH = 1'b0, flipV = 1'b0, scale2 = 1'b0;
   logic        ready, done, aborted;
   logic [8:0]  imgWidth, imgHeight;
   logic [17:0] writeCount;

   sprite_blitter_if #(.ADDR_W(16)) bus ();

   sprite_blitter #(.ROM_LATENCY(L)) dut (
      .clock(clock), .reset(reset), .draw(draw), .abort(abort), .romBase(romBase),
      .xOrigin(xOrigin), .yOrigin(yOrigin), .flipH(flipH), .flipV(flipV), .scale2(scale2),
      .bus(bus), .ready(ready), .done(done), .aborted(aborted), .imgWidth(imgWidth),
      .imgHeight(imgHeight), .writeCount(writeCount)
   );

   always #5 clock = ~clock;

   // ROM with L cycles of address-to-data latency.
   logic [15:0] rom [65536];
   logic [15:0] pipe [L];
   always @(posedge clock) begin
      pipe[0] <= bus.romAddr;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end
   assign bus.romData = rom[pipe[L-1]];

   typedef struct {int x; int y; int col;} px_t;
   px_t exp_q[$];
   int  spr[$];
   int  n_chk = 0, n_fail = 0, cyc = 0;
   int  rdy_mode = 0, stall_left = 0, acc_cnt = 0;
   int  done_cnt = 0, done_cyc = 0, first_pw_cyc = -1, cyc_start = 0, d0 = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // pixelReady: 0 = always 1, 1 = random, other = stall the third write for stall_left cycles
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         0: bus.pixelReady = 1'b1;
         1: bus.pixelReady = 1'($urandom_range(0, 1));
         default:
            if (bus.pixelWrite && acc_cnt == 2 && stall_left > 0) begin
               bus.pixelReady = 1'b0;
               stall_left--;
            end else bus.pixelReady = 1'b1;
      endcase
   end

   bit prev_pw = 0, prev_acc = 0, prev_done = 0;
   int hx, hy, hc;
   always @(negedge clock) begin : monitor
      px_t e;
      int ax, ay, ac;
      if (reset) begin
         prev_pw = 0; prev_acc = 0; prev_done = 0;
      end else begin
         ax = int'(bus.xAddr); ay = int'(bus.yAddr); ac = int'(bus.pixelData);
         if (prev_done) chk(ready == 1'b1, "ready_after_done", int'(ready), 1);
         if (prev_acc) chk(bus.pixelWrite == 1'b0, "write_gap", int'(bus.pixelWrite), 0);
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (bus.pixelWrite) begin
            if (first_pw_cyc < 0) first_pw_cyc = cyc;
            if (prev_pw && !prev_acc)
               chk(ax == hx && ay == hy && ac == hc, "write_stable", ax * 1000 + ay, hx * 1000 + hy);
            hx = ax; hy = ay; hc = ac;
            if (bus.pixelReady) begin
               acc_cnt++;
               if (exp_q.size() == 0) chk(1'b0, "unexpected_write", ax * 1000 + ay, -1);
               else begin
                  e = exp_q.pop_front();
                  chk(ax == e.x, "wr_x", ax, e.x);
                  chk(ay == e.y, "wr_y", ay, e.y);
                  chk(ac == e.col, "wr_colour", ac, e.col);
               end
            end
         end
         prev_pw = bus.pixelWrite; prev_acc = bus.pixelWrite && bus.pixelReady; prev_done = done;
      end
   end

   // Loads spr at base, queues the first `limit` expected writes and raises draw.
   task automatic start_draw(input int base, input int xo, input int yo, input bit fh,
                             input bit fv, input bit s2, input int limit, output int nexp);
      int w, h, s, sc, sr, col, x, y, n;
      for (int k = 0; k < spr.size(); k++) rom[16'(base + k)] = 16'(spr[k]);
      w = spr[0]; h = spr[1]; s = s2 ? 2 : 1; n = 0;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            for (int j = 0; j < s; j++)
               for (int i = 0; i < s; i++) begin
                  sc = fh ? w - 1 - c : c;
                  sr = fv ? h - 1 - r : r;
                  col = spr[2 + sr * w + sc];
                  x = xo + c * s + i;
                  y = yo + r * s + j;
                  if (x >= 0 && x < 240 && y >= 0 && y < 320 && col != int'(T)) begin
                     if (n < limit) exp_q.push_back('{x, y, col});
                     n++;
                  end
               end
      nexp = (n < limit) ? n : limit;
      @(negedge clock);
      romBase = 16'(base); xOrigin = 10'(xo); yOrigin = 10'(yo);
      flipH = fh; flipV = fv; scale2 = s2;
      acc_cnt = 0; first_pw_cyc = -1; d0 = done_cnt; cyc_start = cyc;
      draw = 1'b1;
   endtask

   task automatic finish_draw(input int nexp, input bit exp_ab, input string tag);
      int k = 0;
      while (done_cnt == d0 && k < 20000) begin
         @(negedge clock);
         k++;
         if (k == 2) draw = 1'b0;
      end
      draw = 1'b0;
      chk(done_cnt == d0 + 1, {tag, "_done_pulses"}, done_cnt - d0, 1);
      chk(int'(writeCount) == nexp, {tag, "_writeCount"}, int'(writeCount), nexp);
      chk(aborted == exp_ab, {tag, "_aborted"}, int'(aborted), int'(exp_ab));
      chk(int'(imgWidth) == spr[0], {tag, "_imgWidth"}, int'(imgWidth), spr[0]);
      chk(int'(imgHeight) == spr[1], {tag, "_imgHeight"}, int'(imgHeight), spr[1]);
      chk(exp_q.size() == 0, {tag, "_missing_writes"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (3) @(negedge clock);
   endtask

   initial begin
      int nexp, k, dsave, w, h;
      bit fh, fv, s2;
      repeat (2) @(negedge clock);
      chk(ready == 1'b0 && done == 1'b0 && aborted == 1'b0, "reset_flags",
          {29'd0, ready, done, aborted}, 0);
      chk(bus.pixelWrite == 1'b0 && writeCount == '0 && bus.romAddr == '0, "reset_outputs",
          int'(writeCount) + int'(bus.pixelWrite), 0);
      reset = 1'b0;
      @(negedge clock);
      chk(ready == 1'b1, "ready_after_reset", int'(ready), 1);

      spr = '{2, 2, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
      start_draw(100, 10, 20, 0, 0, 0, 1 << 30, nexp);
      finish_draw(nexp, 0, "basic");
      chk(first_pw_cyc - cyc_start == 3 * (L + 1) + 2, "first_write_latency",
          first_pw_cyc - cyc_start, 3 * (L + 1) + 2);

      start_draw(100, 0, 0, 1, 1, 1, 1 << 30, nexp);
      finish_draw(nexp, 0, "flip_scale");
      chk(nexp == 16, "flip_scale_count", nexp, 16);

      spr = '{3, 1, 5, int'(T), 7};
      start_draw(65534, -1, 319, 0, 0, 0, 1 << 30, nexp);
      finish_draw(nexp, 0, "clip");

      spr = '{0, 3};
      start_draw(500, 5, 5, 0, 0, 0, 1 << 30, nexp);
      finish_draw(nexp, 0, "zero_width");
      chk(done_cyc - cyc_start - 1 <= 2 * (L + 1) + 3, "zero_width_latency",
          done_cyc - cyc_start - 1, 2 * (L + 1) + 3);

      spr = {4, 4};
      for (int p = 0; p < 16; p++) spr.push_back(16'h0100 + p);
      rdy_mode = 2; stall_left = 5;
      start_draw(1000, 50, 60, 0, 0, 0, 3, nexp);
      k = 0;
      while (!(acc_cnt == 2 && bus.pixelWrite) && k < 500) begin @(negedge clock); k++; end
      chk(k < 500, "abort_third_write_seen", k, 500);
      repeat (2) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      finish_draw(nexp, 1, "abort");
      rdy_mode = 0;

      // Reset in the middle of a write, with draw held high throughout.
      start_draw(1000, 70, 80, 0, 0, 0, 1 << 30, nexp);
      k = 0;
      while (!bus.pixelWrite && k < 500) begin @(negedge clock); k++; end
      dsave = done_cnt;
      reset = 1'b1;
      #1;
      chk(bus.pixelWrite == 1'b0, "async_reset_write", int'(bus.pixelWrite), 0);
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk(ready == 1'b1, "ready_after_mid_reset", int'(ready), 1);
      repeat (6) @(negedge clock);
      chk(ready == 1'b1 && writeCount == '0, "no_start_on_held_draw", int'(ready), 1);
      chk(done_cnt == dsave, "no_done_on_reset", done_cnt - dsave, 0);
      draw = 1'b0;
      @(negedge clock);
      spr = '{2, 2, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
      start_draw(100, 10, 20, 0, 0, 0, 1 << 30, nexp);
      finish_draw(nexp, 0, "after_reset");

      for (int t = 0; t < 24; t++) begin
         w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
         h = int'($urandom_range(1, 5));
         spr = {w, h};
         for (int p = 0; p < w * h; p++)
            spr.push_back(($urandom_range(0, 3) == 0) ? int'(T) : int'($urandom_range(2, 65535)));
         fh = 1'($urandom_range(0, 1)); fv = 1'($urandom_range(0, 1));
         s2 = 1'($urandom_range(0, 1));
         rdy_mode = int'($urandom_range(0, 1));
         start_draw(int'($urandom_range(0, 65535)), int'($urandom_range(0, 270)) - 15,
                    int'($urandom_range(0, 350)) - 15, fh, fv, s2, 1 << 30, nexp);
         finish_draw(nexp, 0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite-drawing engine that copies a sprite image from a sprite ROM to the LT24 pixel-write interface. It sits between game or demo control logic and the LT24Display driver. Over a single-sprite, fixed-ROM drawer it adds:
- configurable screen geometry and ROM latency;
- per-draw base address selection;
- horizontal and vertical flip;
- 1x/2x integer scaling;
- full-screen clipping with negative origins;
- abort, a completion pulse and a pixel-write count.

## Interface
Parameters:
- SCREEN_W, 240: visible x range 0..SCREEN_W-1.
- SCREEN_H, 320: visible y range 0..SCREEN_H-1.
- ROM_LATENCY, 2: cycles from romAddr change to valid romData (1..7).
- ADDR_W, 16: ROM address width.
- TRANSPARENT, 16'h0001: colour value that is never written.

Ports:
- clock  in  1  system clock, all logic on posedge. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high.
- draw  in  1  start request; acts on its rising edge only.
- abort  in  1  synchronous stop request.
- romBase  in  ADDR_W  sprite header address, sampled at start.
- xOrigin  in  10  signed screen x of sprite pixel (0,0), sampled at start.
- yOrigin  in  10  signed screen y of sprite pixel (0,0), sampled at start.
- flipH  in  1  mirror columns; sampled at start.
- flipV  in  1  mirror rows; sampled at start.
- scale2  in  1  draw each source pixel as a 2x2 block; sampled at start.
- romAddr  out  ADDR_W  ROM address.
- romData  in  16  ROM word.
- xAddr  out  8  LCD x.
- yAddr  out  9  LCD y.
- pixelData  out  16  LCD colour.
- pixelWrite  out  1  write request.
- pixelReady  in  1  LCD accepts the write.
- ready  out  1  idle, able to accept draw.
- done  out  1  one-cycle pulse at end of a draw, whether completed or aborted.
- aborted  out  1  last draw ended by abort; held until the next start.
- imgWidth  out  9  sprite width, from header word 0 bits [8:0].
- imgHeight  out  9  sprite height, from header word 1 bits [8:0].
- writeCount  out  18  pixels accepted by the LCD in the current or last draw.

## Operation
- ROM layout:
  - romBase+0 = width W.
  - romBase+1 = height H.
  - Pixels are row-major from romBase+2.
- Source pixel (c,r): sc = flipH ? W-1-c : c; sr = flipV ? H-1-r : r; romAddr = romBase + 2 + sr*W + sc, truncated to ADDR_W (wraps).
- Scale factor S = 2 if scale2 else 1.
- Destination of (c,r) with sub-offset (i,j), i,j < S: x = xOrigin + c*S + i, y = yOrigin + r*S + j. Signed 11-bit arithmetic.
- Write happens only if 0<=x<SCREEN_W, 0<=y<SCREEN_H and colour != TRANSPARENT. Otherwise the sub-pixel is skipped.
- Traversal order:
  - Sub-pixels i then j within a source pixel.
  - Then c from 0 to W-1.
  - Then r from 0 to H-1.
- States:
  - IDLE: ready=1. A rising draw edge (draw=1 at this edge, 0 at the previous one) latches the inputs, clears writeCount and aborted, and moves to HDR_W.
  - HDR_W: romAddr=romBase; sample after the latency wait.
  - HDR_H: romAddr=romBase+1; sample after the latency wait. If W=0 or H=0, go to DONE.
  - FETCH: drive romAddr, wait ROM_LATENCY+1 cycles, latch colour.
  - EMIT: evaluate the current sub-pixel. If writable, drive xAddr/yAddr/pixelData with pixelWrite=1 and go to WRITE. Otherwise go to ADVANCE.
  - WRITE: hold outputs until pixelWrite && pixelReady at an edge. Then pixelWrite=0 and writeCount+1 (saturating).
  - ADVANCE: next sub-pixel goes to EMIT. Next source pixel goes to FETCH. Past the last pixel goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- A draw held high across DONE does not retrigger.
- abort while busy:
  - Outside WRITE: go to DONE next edge.
  - In WRITE: the pending write completes first.
  - In both cases aborted=1.
- abort in IDLE is ignored. abort and a draw edge together in IDLE: start wins.
- Reset values: all outputs are 0, state IDLE. ready rises on the first clock after reset release.
- Reset mid-draw: pixelWrite drops immediately (asynchronously), with no done pulse.

## Timing
- Start edge at N: romAddr=romBase from N. imgWidth is valid after edge N+ROM_LATENCY+1. imgHeight is valid ROM_LATENCY+1 cycles later.
- First pixelWrite assertion: edge N + 3*(ROM_LATENCY+1) + 1, assuming an unclipped, opaque pixel.
- Costs per step:
  - Each skipped sub-pixel: 2 cycles (EMIT, ADVANCE).
  - Each written sub-pixel: 3 cycles plus pixelReady wait.
  - Each fetch: ROM_LATENCY+1.
- xAddr/yAddr/pixelData are stable for the entire time pixelWrite=1.
- Successive writes have at least one cycle with pixelWrite=0 between them.
- done pulses exactly one cycle before ready returns to 1.

## Test plan
- 2x2 sprite, words {2,2,A,B,C,D}, origin (10,20), no flip, pixelReady always 1 -> writes (10,20)=A, (11,20)=B, (10,21)=C, (11,21)=D in order; writeCount=4; one done pulse.
- Same sprite, flipH=1, flipV=1, scale2=1, origin (0,0) -> 16 writes. (0..1,0..1)=D; the block at (2..3,2..3)=A; writeCount=16.
- 3x1 sprite {3,1,5,TRANSPARENT,7}, origin (-1,319) -> only (1,319)=7 written. x=-1 is clipped and the transparent pixel is skipped; writeCount=1.
- Header W=0 -> no pixelWrite; done within 2*(ROM_LATENCY+1)+3 cycles of the start edge; imgWidth=0.
- 4x4 opaque sprite, pixelReady held 0 for 5 cycles on the 3rd write, abort pulsed during that write -> the 3rd write completes with addresses stable; no 4th write; aborted=1; writeCount=3.
- Assert reset while pixelWrite=1 -> pixelWrite=0 before the next edge; ready=1 one cycle after release. Draw held high through reset, then low->high -> exactly one new draw.
